voice_allocator: RTL

Polyphonic voice scheduler between the MIDI front end and a bank of NUM_VOICES synth voices (oscillator plus ADSR envelope each). It accepts channel-0 MIDI events through a valid/ready handshake and assigns each NOTE_ON to a voice. Assignment priority is same-note retrigger, then a fully idle voice, then a released voice, then stealing the oldest voice. NOTE_OFF drops the gate of the voice holding that note. All other events are consumed and ignored; pitch bend and CC stay with the existing global controls.

---
 rtl/voice_allocator.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: assigns channel-0 NOTE_ON events to voices
// (retrigger > idle > released > steal oldest) and drops gates on NOTE_OFF.
module voice_allocator #(
  parameter int NUM_VOICES = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    event_valid_in,
  input  logic [23:0]             event_in,
  output logic                    event_ready_out,
  input  logic [NUM_VOICES-1:0]   voice_idle_in,
  output logic [NUM_VOICES-1:0]   gate_out,
  output logic [NUM_VOICES-1:0]   trigger_out,
  output logic [8*NUM_VOICES-1:0] note_out,
  output logic [7*NUM_VOICES-1:0] velocity_out,
  output logic                    steal_out,
  output logic [1:0]              state_out
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2} state_t;

  state_t state, state_n;

  // Handshake: an event transfers on a rising edge where event_valid_in and
  // event_ready_out are both high; ready depends only on the FSM state.
  logic accept, is_on, is_off;
  logic [7:0] in_status;
  logic [6:0] in_note, in_vel;
  logic unused_bits;

  assign in_status       = event_in[23:16];
  assign in_note         = event_in[14:8];
  assign in_vel          = event_in[6:0];
  assign unused_bits     = ^{event_in[15], event_in[7]};
  assign event_ready_out = (state == IDLE);
  assign accept          = event_valid_in && event_ready_out;
  assign is_on           = (in_status == 8'h90) && (in_vel != 7'd0);
  assign is_off          = (in_status == 8'h80) || ((in_status == 8'h90) && (in_vel == 7'd0));
  assign state_out       = state;

  logic                  ev_on;
  logic [6:0]            ev_note, ev_vel;
  logic [IW-1:0]         idx;
  logic                  match_found, free_found, rel_found;
  logic [IW-1:0]         match_idx, free_idx, rel_idx, old_idx;

  logic [NUM_VOICES-1:0] gate_q, trigger_q;
  logic                  steal_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];
  logic [IW-1:0]         age_q  [NUM_VOICES];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && (is_on || is_off)) state_n = SCAN;
      SCAN:    if (idx == LAST) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Candidate search: first hit wins, so each candidate is the lowest index.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ev_on       <= 1'b0;
      ev_note     <= '0;
      ev_vel      <= '0;
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      rel_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      rel_idx     <= '0;
      old_idx     <= '0;
    end else if (accept) begin
      ev_on       <= is_on;
      ev_note     <= in_note;
      ev_vel      <= in_vel;
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      rel_found   <= 1'b0;
    end else if (state == SCAN) begin
      idx <= idx + 1'b1;
      if (!match_found && gate_q[idx] && (note_q[idx] == ev_note)) begin
        match_found <= 1'b1;
        match_idx   <= idx;
      end
      if (!free_found && !gate_q[idx] && voice_idle_in[idx]) begin
        free_found <= 1'b1;
        free_idx   <= idx;
      end
      if (!rel_found && !gate_q[idx]) begin
        rel_found <= 1'b1;
        rel_idx   <= idx;
      end
      if (age_q[idx] == LAST) old_idx <= idx;
    end
  end

  logic [IW-1:0] target;
  logic          steal_sel;

  always_comb begin
    target    = old_idx;
    steal_sel = 1'b1;
    if (match_found) begin
      target    = match_idx;
      steal_sel = 1'b0;
    end else if (free_found) begin
      target    = free_idx;
      steal_sel = 1'b0;
    end else if (rel_found) begin
      target    = rel_idx;
      steal_sel = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gate_q    <= '0;
      trigger_q <= '0;
      steal_q   <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= IW'(NUM_VOICES - 1 - i);
      end
    end else begin
      trigger_q <= '0;
      steal_q   <= 1'b0;
      if (state == COMMIT) begin
        if (ev_on) begin
          gate_q[target]    <= 1'b1;
          trigger_q[target] <= 1'b1;
          note_q[target]    <= ev_note;
          vel_q[target]     <= ev_vel;
          steal_q           <= steal_sel;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (age_q[i] < age_q[target]) age_q[i] <= age_q[i] + 1'b1;
          end
          age_q[target] <= '0;
        end else if (match_found) begin
          // Note and velocity stay so the release phase keeps its pitch.
          gate_q[match_idx] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    note_out     = '0;
    velocity_out = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      note_out[8*i +: 8]     = {1'b0, note_q[i]};
      velocity_out[7*i +: 7] = vel_q[i];
    end
  end

  assign gate_out    = gate_q;
  assign trigger_out = trigger_q;
  assign steal_out   = steal_q;

endmodule
